// File: rtl/us_alarm.sv
// rtl/us_alarm.sv - microsecond alarm/interrupt peripheral with coherent 32-bit count reads
//
// Ports:
//   clk       system clock
//   rst       asynchronous reset, active-high
//   us_count  free-running 32-bit microsecond count (wraps 2^32-1 -> 0)
//   io_addr   word register select (0..7)
//   io_wr     write strobe, one cycle per access
//   io_rd     read strobe, one cycle per access
//   io_din    16-bit write data
//   io_dout   16-bit registered read data, held until the next read
//   irq       registered level interrupt (pending & irq_en)
//
// Register map (word addresses):
//   0 COUNT_LO  R    us_count[15:0]; latches us_count[31:16] into the shadow
//   1 COUNT_HI  R    shadow copy of the upper half taken at the COUNT_LO read
//   2 ALARM_LO  R/W  write stages the low half; read returns committed alarm[15:0]
//   3 ALARM_HI  R/W  write commits {io_din, staged low} and arms; read alarm[31:16]
//   4 PERIOD_LO R/W  write stages the low half; read returns committed period[15:0]
//   5 PERIOD_HI R/W  write commits {io_din, staged low}; read period[31:16]
//   6 CTRL      R/W  bit0 irq_en, bit1 periodic, bit2 armed (write 0 disarms only)
//   7 STATUS    R/W1C bit0 pending
module us_alarm #(
    parameter logic [31:0] RESET_PERIOD = 32'd1000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] us_count,
    input  logic [2:0]  io_addr,
    input  logic        io_wr,
    input  logic        io_rd,
    input  logic [15:0] io_din,
    output logic [15:0] io_dout,
    output logic        irq
);

    localparam logic [2:0] A_COUNT_LO  = 3'd0;
    localparam logic [2:0] A_COUNT_HI  = 3'd1;
    localparam logic [2:0] A_ALARM_LO  = 3'd2;
    localparam logic [2:0] A_ALARM_HI  = 3'd3;
    localparam logic [2:0] A_PERIOD_LO = 3'd4;
    localparam logic [2:0] A_PERIOD_HI = 3'd5;
    localparam logic [2:0] A_CTRL      = 3'd6;
    localparam logic [2:0] A_STATUS    = 3'd7;

    logic [15:0] shadow_hi;
    logic [31:0] alarm;
    logic [15:0] alarm_lo_stage;
    logic [31:0] period;
    logic [15:0] period_lo_stage;
    logic        irq_en;
    logic        periodic;
    logic        armed;
    logic        pending;

    logic        wr_alarm_hi;
    logic        wr_ctrl;
    logic        disarm;
    logic        w1c;
    logic        due;
    logic        fire;
    logic        reload;
    logic [15:0] rd_data;

    assign wr_alarm_hi = io_wr && (io_addr == A_ALARM_HI);
    assign wr_ctrl     = io_wr && (io_addr == A_CTRL);
    assign disarm      = wr_ctrl && !io_din[2];
    assign w1c         = io_wr && (io_addr == A_STATUS) && io_din[0];

    // The alarm counts as reached when us_count is at or past it by less than
    // 2^31 us, so the test survives the 32-bit wrap of the timer. An alarm set
    // further than that in the past looks like a future one.
    assign due    = armed && ((us_count - alarm) < 32'h8000_0000);

    // A fresh ALARM_HI commit or an explicit disarm in the same cycle overrides
    // a due of the old alarm.
    assign fire   = due && !wr_alarm_hi && !disarm;

    // Periodic reload advances from the old alarm value, not from us_count,
    // so the schedule never drifts; a late alarm keeps firing until caught up.
    assign reload = periodic && (period != 32'd0);

    always_comb begin
        rd_data = 16'd0;
        case (io_addr)
            A_COUNT_LO:  rd_data = us_count[15:0];
            A_COUNT_HI:  rd_data = shadow_hi;
            A_ALARM_LO:  rd_data = alarm[15:0];
            A_ALARM_HI:  rd_data = alarm[31:16];
            A_PERIOD_LO: rd_data = period[15:0];
            A_PERIOD_HI: rd_data = period[31:16];
            A_CTRL:      rd_data = {13'd0, armed, periodic, irq_en};
            A_STATUS:    rd_data = {15'd0, pending};
            default:     rd_data = 16'd0;
        endcase
    end

    // Read path and count shadow
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            io_dout   <= 16'd0;
            shadow_hi <= 16'd0;
        end else if (io_rd) begin
            io_dout <= rd_data;
            if (io_addr == A_COUNT_LO) begin
                shadow_hi <= us_count[31:16];
            end
        end
    end

    // Staging and period registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm_lo_stage  <= 16'd0;
            period_lo_stage <= RESET_PERIOD[15:0];
            period          <= RESET_PERIOD;
        end else if (io_wr) begin
            case (io_addr)
                A_ALARM_LO:  alarm_lo_stage  <= io_din;
                A_PERIOD_LO: period_lo_stage <= io_din;
                A_PERIOD_HI: period          <= {io_din, period_lo_stage};
                default: ;
            endcase
        end
    end

    // Control bits
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq_en   <= 1'b0;
            periodic <= 1'b0;
        end else if (wr_ctrl) begin
            irq_en   <= io_din[0];
            periodic <= io_din[1];
        end
    end

    // Alarm, arm state and pending flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            alarm   <= 32'd0;
            armed   <= 1'b0;
            pending <= 1'b0;
        end else begin
            if (wr_alarm_hi) begin
                alarm <= {io_din, alarm_lo_stage};
                armed <= 1'b1;
            end else if (disarm) begin
                armed <= 1'b0;
            end else if (fire) begin
                if (reload) begin
                    alarm <= alarm + period;
                end else begin
                    armed <= 1'b0;
                end
            end

            // Setting wins over a same-cycle W1C so no event is lost.
            if (fire) begin
                pending <= 1'b1;
            end else if (w1c) begin
                pending <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            irq <= 1'b0;
        end else begin
            irq <= pending && irq_en;
        end
    end

endmodule
